// File: rtl/fft_pkg.sv
// Shared definitions for the SDF FFT datapath: default sample width, the
// delay-line FSM state type and the per-stage delay helper.
package fft_pkg;

  localparam int FFT_DW = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sdf_state_t;

  // Delay of radix-2 SDF stage 'stage' in an n-point FFT: n / 2^(stage+1).
  function automatic int stage_delay(input int n, input int stage);
    return n >> (stage + 1);
  endfunction

endpackage

// File: rtl/sdf_shift_mem.sv
// Enabled DEPTH-entry shift register for packed {valid, r, i} samples; the
// oldest entry (DEPTH-1) is exposed as a registered tap.
module sdf_shift_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 49
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tap
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: every entry is reset, not just the tap; the valid bit travels with
  // the data, so stale entries would otherwise surface as valid outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign tap = mem[DEPTH-1];

endmodule

// File: rtl/sdf_delay_line.sv
// Complex-sample delay line for one radix-2 SDF FFT stage with valid tracking,
// zero-fill drain and butterfly-phase select. Define SDF_FLUSH_EN to add a
// synchronous 'flush' input that clears all state.
module sdf_delay_line
  import fft_pkg::*;
#(
  parameter  int DW    = FFT_DW,
  parameter  int DEPTH = 16,
  localparam int PW    = ($clog2(2 * DEPTH) < 1) ? 1 : $clog2(2 * DEPTH),
  localparam int CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
`ifdef SDF_FLUSH_EN
  input  logic                 flush,
`endif
  input  logic                 in_valid,
  input  logic signed [DW-1:0] din_r,
  input  logic signed [DW-1:0] din_i,
  output logic signed [DW-1:0] dout_r,
  output logic signed [DW-1:0] dout_i,
  output logic                 out_valid,
  output logic                 bf_sel,
  output logic                 busy
);

  sdf_state_t      state, state_d;
  logic [PW-1:0]   phase, phase_d;
  logic [CW-1:0]   drain_cnt, drain_d;
  logic            advance;
  logic            clr;
  logic [2*DW:0]   mem_din;
  logic [2*DW:0]   mem_tap;

`ifdef SDF_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  assign advance = in_valid | (state == DRAIN);
  // Zero-fill whenever the shift is driven by the drain rather than a sample.
  assign mem_din = in_valid ? {1'b1, din_r, din_i} : '0;

  // NOTE: defaults first so every path assigns every output; no latches.
  always_comb begin
    state_d = state;
    drain_d = drain_cnt;
    phase_d = phase;
    case (state)
      IDLE:  if (in_valid) state_d = RUN;
      RUN: begin
        if (!in_valid) begin
          state_d = DRAIN;
          drain_d = CW'(DEPTH - 1);
        end
      end
      DRAIN: begin
        if (drain_cnt != '0) drain_d = drain_cnt - 1'b1;
        if (in_valid)               state_d = RUN;
        else if (drain_cnt == '0)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A fresh burst restarts the phase; resuming out of DRAIN does not.
    if (state == IDLE && in_valid)
      phase_d = '0;
    else if (advance)
      phase_d = (phase == PW'(2 * DEPTH - 1)) ? '0 : phase + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      phase     <= '0;
      drain_cnt <= '0;
    end else if (clr) begin
      state     <= IDLE;
      phase     <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_d;
      phase     <= phase_d;
      drain_cnt <= drain_d;
    end
  end

  sdf_shift_mem #(
    .DEPTH (DEPTH),
    .WIDTH (2 * DW + 1)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .en      (advance),
    .din     (mem_din),
    .tap     (mem_tap)
  );

  assign {out_valid, dout_r, dout_i} = mem_tap;
  assign bf_sel = (phase >= PW'(DEPTH));
  assign busy   = (state != IDLE);

endmodule
